sr2dr_altsp_bus: RTL
====================

SR2DR_ALTSP_BUS -- requirements
Module: sr2dr_altsp_bus

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits; each bit maps to one rail pair; legal range 1..64.
REQ-002 Parameter SP_MODE, default 0: 0 = alternating spacer, 1 = all-zeros spacer only, 2 = all-ones spacer only.
REQ-003 Parameter CNT_W, default 16: width of the codeword counter.
REQ-004 C  input  1: single clock; all state updates on the rising edge.
REQ-005 R  input  1: reset, synchronous, active-high.
REQ-006 in_valid  input  1: single-rail word on in_data is offered.
REQ-007 in_ready  output  1: block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH: single-rail data word.
REQ-009 dr_1  output  WIDTH: dual-rail true rails, registered.
REQ-010 dr_0  output  WIDTH: dual-rail false rails, registered.
REQ-011 ack  input  1: receiver completion, return-to-zero; high = codeword received, low = spacer received.
REQ-012 sp_phase  output  1: polarity of the current or most recent spacer; 0 = all-zeros, 1 = all-ones.
REQ-013 cw_cnt  output  CNT_W: number of codewords completed (acked) since reset.
REQ-014 err  output  1: sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have two states: SP (driving spacer) and CW (driving codeword).
REQ-016 Spacer encoding SHALL be dr_1 = dr_0 = all-zeros when sp_phase = 0, and dr_1 = dr_0 = all-ones when sp_phase = 1.
REQ-017 Codeword encoding SHALL be independent of sp_phase: bit value 1 -> (dr_1, dr_0) = (1, 0); bit value 0 -> (0, 1).
REQ-018 in_ready SHALL equal (state == SP) AND NOT ack, combinationally.
REQ-019 When in_valid AND in_ready are both high, in_data SHALL be captured and driven as a codeword on dr_1/dr_0 from the next cycle; the FSM enters CW. Latency is 1 cycle.
REQ-020 In CW, the codeword SHALL be held unchanged until ack is sampled high.
REQ-021 When ack is sampled high in CW, the FSM SHALL return to SP on the next cycle and drive the next spacer, and cw_cnt SHALL increment by 1 on the same edge.
REQ-022 Next-spacer polarity SHALL toggle for SP_MODE 0, stay 0 for SP_MODE 1, and stay 1 for SP_MODE 2; sp_phase SHALL update on the same edge the spacer is driven.
REQ-023 cw_cnt SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-024 A spacer SHALL be driven for at least one full cycle between two codewords; this follows from REQ-018 because ack is still high on the first SP cycle.
REQ-025 If in_valid is low in SP, the spacer SHALL be held indefinitely.
REQ-026 err SHALL set when ack rises (0 to 1, sampled against its registered previous value) while the FSM is in SP, and SHALL stay set until reset.
REQ-027 The FSM SHALL not react to an ack fall while in CW; ack is only evaluated for the high level in CW.
REQ-028 Every output transition on dr_1/dr_0 SHALL be a single spacer<->codeword step; codeword-to-codeword transitions SHALL never occur.

Reset
REQ-029 While R is high at a rising edge, the next state SHALL be: FSM in SP, cw_cnt = 0, err = 0, stored ack = 0, and sp_phase = 1 for SP_MODE 2, else 0.
REQ-030 dr_1/dr_0 SHALL show the reset spacer on the cycle after R is sampled high, including when R is asserted mid-codeword.
REQ-031 in_ready SHALL be low while R is high.

Structure
REQ-032 Package sr2dr_pkg SHALL hold the SP_MODE encodings (SP_ALT, SP_ZERO, SP_ONE) and the state enum (ST_SP, ST_CW).
REQ-033 Spacer-polarity generation (reset value, toggle or hold per SP_MODE, advance strobe) SHALL be a sub-module named alt_spgen; everything else SHALL stay in one module.

Verification
REQ-034 SP_MODE 0, WIDTH 8: send 0xA5 and then 0x3C with ack returning one cycle after each change -> dr_1/dr_0 sequence 00/00, A5/5A, FF/FF, 3C/C3, 00/00; cw_cnt = 2.
REQ-035 SP_MODE 1: send three words -> every spacer is all-zeros and sp_phase stays 0; SP_MODE 2 -> every spacer is all-ones and sp_phase stays 1.
REQ-036 ack held high for 5 cycles after the codeword is acked -> spacer is held and in_ready stays low until ack falls; the next word is accepted the cycle ack = 0.
REQ-037 R asserted while in CW with 0xFF -> next cycle dr_1 = dr_0 = 0x00, cw_cnt = 0, sp_phase = 0.
REQ-038 ack pulsed high while in SP with no codeword -> err = 1 and stays 1; CNT_W = 2 with 5 words -> cw_cnt = 1.

Source files
------------

// File: rtl/sr2dr_pkg.sv
// Shared encodings for the single-rail to dual-rail converter: spacer modes and FSM states.
// No logic; latency and backpressure are defined by the modules importing this package.
package sr2dr_pkg;

  localparam int SP_ALT  = 0;
  localparam int SP_ZERO = 1;
  localparam int SP_ONE  = 2;

  typedef enum logic {
    ST_SP = 1'b0,
    ST_CW = 1'b1
  } state_t;

  // Spacer polarity the bus comes out of reset with.
  function automatic logic reset_phase(input int mode);
    return (mode == SP_ONE);
  endfunction

endpackage

// File: rtl/sr2dr_altsp_bus_alt_spgen.sv
// Spacer polarity generator: sp_next is the polarity the next spacer will use, sp_phase updates with it.
// Advances one step per adv strobe; no backpressure.
module alt_spgen
  import sr2dr_pkg::*;
#(
  parameter int SP_MODE = SP_ALT
) (
  input  logic C,
  input  logic R,
  input  logic adv,
  output logic sp_phase,
  output logic sp_next
);

  localparam logic RST_PH = reset_phase(SP_MODE);

  always_comb begin
    sp_next = sp_phase;
    if (adv) begin
      if (SP_MODE == SP_ALT) sp_next = ~sp_phase;
      else                   sp_next = RST_PH;
    end
  end

  always_ff @(posedge C) begin
    if (R) sp_phase <= RST_PH;
    else   sp_phase <= sp_next;
  end

endmodule

// File: rtl/sr2dr_altsp_bus.sv
// Single-rail to dual-rail return-to-spacer bus driver; word reaches dr_1/dr_0 one cycle after accept.
// in_ready drops while a codeword is outstanding or the receiver ack is still high.
module sr2dr_altsp_bus
  import sr2dr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SP_MODE = SP_ALT,
  parameter int CNT_W   = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dr_1,
  output logic [WIDTH-1:0] dr_0,
  input  logic             ack,
  output logic             sp_phase,
  output logic [CNT_W-1:0] cw_cnt,
  output logic             err
);

  localparam logic RST_PH = reset_phase(SP_MODE);

  state_t state, state_nxt;
  logic   ack_q;
  logic   accept;
  logic   cw_done;
  logic   sp_next;

  assign in_ready = (state == ST_SP) && !ack && !R;
  assign accept   = in_valid && in_ready;
  assign cw_done  = (state == ST_CW) && ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SP:   if (accept) state_nxt = ST_CW;
      ST_CW:   if (ack)    state_nxt = ST_SP;
      default: state_nxt = ST_SP;
    endcase
  end

  alt_spgen #(
    .SP_MODE (SP_MODE)
  ) u_spgen (
    .C        (C),
    .R        (R),
    .adv      (cw_done),
    .sp_phase (sp_phase),
    .sp_next  (sp_next)
  );

  // dr_1/dr_0 change only on accept or on codeword completion, so every step is spacer<->codeword.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= ST_SP;
      ack_q  <= 1'b0;
      err    <= 1'b0;
      cw_cnt <= '0;
      dr_1   <= {WIDTH{RST_PH}};
      dr_0   <= {WIDTH{RST_PH}};
    end else begin
      state <= state_nxt;
      ack_q <= ack;
      if ((state == ST_SP) && ack && !ack_q) err <= 1'b1;
      if (cw_done) begin
        cw_cnt <= cw_cnt + CNT_W'(1);
        dr_1   <= {WIDTH{sp_next}};
        dr_0   <= {WIDTH{sp_next}};
      end else if (accept) begin
        dr_1 <= in_data;
        dr_0 <= ~in_data;
      end
    end
  end

endmodule
